instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter ADDRESS_BITWIDTH, default 12, meaning the instruction-memory word address width; depth = 2^ADDRESS_BITWIDTH words.
REQ-002 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  is the reset: one clock, asynchronous, active-high.
REQ-004 Port in_data  input  8  carries a byte of the boot stream.
REQ-005 Port in_valid  input  1  means in_data holds a valid byte.
REQ-006 Port in_ready  output  1  means the block accepts a byte this cycle.
REQ-007 Port reload  input  1  is a request to restart loading; honored only in DONE or ERROR.
REQ-008 Port rom_wren  output  1  is the instruction-memory write enable.
REQ-009 Port rom_address  output  ADDRESS_BITWIDTH  is the instruction-memory word address.
REQ-010 Port rom_write_data  output  32  is the instruction word to write.
REQ-011 Port cpu_reset_n  output  1  holds the CPU in reset while low.
REQ-012 Port done  output  1  means the load completed successfully.
REQ-013 Port error  output  1  means the header was rejected.

Function
REQ-014 A byte SHALL be accepted only on a rising edge with in_valid=1 and in_ready=1.
REQ-015 in_ready SHALL be 1 in states LEN and LOAD, and 0 in states DONE and ERROR.
REQ-016 Bytes SHALL assemble into 32-bit words little-endian: the first accepted byte goes to bits [7:0] and the fourth to bits [31:24].
  - A 2-bit byte counter wraps 3->0 after the fourth byte.
REQ-017 Stream format: one header word N (the word count), then exactly N instruction words.
REQ-018 In state LEN, acceptance of the fourth header byte SHALL latch N and set the next state.
  - N=0 or N>2^ADDRESS_BITWIDTH -> ERROR.
  - Otherwise -> LOAD, with the word index cleared to 0.
REQ-019 In state LOAD, on acceptance of the fourth byte of a word, the outputs SHALL be registered for the following cycle.
  - rom_wren=1 for exactly that one cycle.
  - rom_address = the current word index; rom_write_data = the assembled word.
  - The word index then increments.
REQ-020 The word-write latency SHALL be one cycle: rom_wren is high in the cycle immediately after the handshake edge of the fourth byte.
REQ-021 When the write of word index N-1 is issued, the state SHALL become DONE on the same edge.
  - done=1 and cpu_reset_n=1 become visible in the cycle after rom_wren's final high cycle.
REQ-022 rom_wren SHALL be 0 in every cycle not covered by REQ-019; rom_address and rom_write_data SHALL hold their last values when rom_wren=0.
REQ-023 cpu_reset_n SHALL be 0 in every state except DONE.
REQ-024 In state ERROR, error=1 and done=0; no memory write SHALL occur.
REQ-025 reload=1 in DONE or ERROR SHALL move the state to LEN on the next edge.
  - Same edge clears done, error, the byte counter and the word index, and drops cpu_reset_n to 0.
  - reload in LEN or LOAD SHALL be ignored.
REQ-026 Gaps (in_valid=0) at any point SHALL stall progress without losing partial-word bytes.
REQ-027 When N=2^ADDRESS_BITWIDTH, the word index SHALL reach the maximum address and the final write SHALL go to address 2^ADDRESS_BITWIDTH-1 with no wrap to 0.

Reset
REQ-028 On reset, all of the following SHALL hold immediately and asynchronously:
  - state=LEN; byte counter, word index and N cleared.
  - rom_wren=0, rom_address=0, rom_write_data=0.
  - cpu_reset_n=0, done=0, error=0.
  - in_ready=1 once reset deasserts.
REQ-029 Reset asserted mid-word or mid-load SHALL discard the partial word; after release the next byte SHALL be treated as header byte 0.

Verification
REQ-030 Stream 02 00 00 00, 13 00 00 00, B7 00 00 00 sent back-to-back -> two single-cycle rom_wren pulses: address 0 data 0x00000013, then address 1 data 0x000000B7; done=1 and cpu_reset_n=1 in the following cycle.
REQ-031 Header 00 00 00 00 -> error=1, in_ready=0, no rom_wren, cpu_reset_n=0; reload=1 -> LEN, error=0, in_ready=1.
REQ-032 Header N=1 with in_valid toggled 1/0 every cycle across the data bytes EF BE AD DE -> one write, address 0, data 0xDEADBEEF.
REQ-033 ADDRESS_BITWIDTH=2, header N=5 -> ERROR; header N=4 followed by 4 words -> writes to addresses 0..3, done=1.
REQ-034 Reset asserted after 2 data bytes of word 1 -> all outputs at reset values; a subsequent full stream with N=1 loads correctly to address 0.
REQ-035 In DONE, drive in_valid=1 for 10 cycles -> in_ready=0 and no rom_wren throughout; then reload=1 -> cpu_reset_n=0 on the next edge.

Source files
------------

// File: rtl/instruction_loader.sv
// Boot-stream loader: assembles little-endian bytes into 32-bit words, takes the
// first word as a word count N, then writes N instruction words to memory.
module instruction_loader #(
  parameter int ADDRESS_BITWIDTH = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        reload,
  output logic                        rom_wren,
  output logic [ADDRESS_BITWIDTH-1:0] rom_address,
  output logic [31:0]                 rom_write_data,
  output logic                        cpu_reset_n,
  output logic                        done,
  output logic                        error
);

  typedef enum logic [1:0] {LEN, LOAD, DONE, ERROR} state_t;

  localparam logic [32:0] DEPTH = 33'd1 << ADDRESS_BITWIDTH;

  state_t                      state;
  logic [1:0]                  byte_cnt;
  logic [23:0]                 partial;
  logic [ADDRESS_BITWIDTH-1:0] word_idx;
  logic [ADDRESS_BITWIDTH-1:0] last_idx;

  logic        accept;
  logic [31:0] word;

  always_comb begin
    accept = in_valid && in_ready;
    word   = {in_data, partial};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= LEN;
      byte_cnt       <= '0;
      partial        <= '0;
      word_idx       <= '0;
      last_idx       <= '0;
      in_ready       <= 1'b1;
      rom_wren       <= 1'b0;
      rom_address    <= '0;
      rom_write_data <= '0;
      cpu_reset_n    <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      rom_wren <= 1'b0;
      case (state)
        LEN, LOAD: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0:    partial[7:0]   <= in_data;
              2'd1:    partial[15:8]  <= in_data;
              2'd2:    partial[23:16] <= in_data;
              default: ;
            endcase
            if (byte_cnt == 2'd3) begin
              if (state == LEN) begin
                if (word == '0 || {1'b0, word} > DEPTH) begin
                  state    <= ERROR;
                  error    <= 1'b1;
                  in_ready <= 1'b0;
                end else begin
                  // N is kept as N-1 so a full-depth load still fits the index width
                  state    <= LOAD;
                  last_idx <= ADDRESS_BITWIDTH'(word - 32'd1);
                  word_idx <= '0;
                end
              end else begin
                rom_wren       <= 1'b1;
                rom_address    <= word_idx;
                rom_write_data <= word;
                if (word_idx == last_idx) begin
                  state    <= DONE;
                  in_ready <= 1'b0;
                end else begin
                  word_idx <= word_idx + ADDRESS_BITWIDTH'(1);
                end
              end
            end
          end
        end
        DONE: begin
          if (reload) begin
            state       <= LEN;
            in_ready    <= 1'b1;
            done        <= 1'b0;
            cpu_reset_n <= 1'b0;
            byte_cnt    <= '0;
            word_idx    <= '0;
          end else begin
            // Released one cycle after entering DONE, i.e. after the final write
            done        <= 1'b1;
            cpu_reset_n <= 1'b1;
          end
        end
        ERROR: begin
          if (reload) begin
            state    <= LEN;
            in_ready <= 1'b1;
            error    <= 1'b0;
            byte_cnt <= '0;
            word_idx <= '0;
          end
        end
        default: state <= LEN;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: two instances (12-bit and 2-bit address) checked
// every cycle against a stream-level model, plus literal expectations per scenario.
module tb_instruction_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0][7:0]  in_data;
  logic [1:0]       in_valid;
  logic [1:0]       reload;

  logic [1:0]       in_ready_w, rom_wren_w, cpu_w, done_w, err_w;
  logic [1:0][11:0] addr_w;
  logic [1:0][31:0] data_w;

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int AW = (gi == 0) ? 12 : 2;
    logic [AW-1:0] a;
    instruction_loader #(.ADDRESS_BITWIDTH(AW)) dut (
      .clk            (clk),
      .reset          (rst[gi]),
      .in_data        (in_data[gi]),
      .in_valid       (in_valid[gi]),
      .in_ready       (in_ready_w[gi]),
      .reload         (reload[gi]),
      .rom_wren       (rom_wren_w[gi]),
      .rom_address    (a),
      .rom_write_data (data_w[gi]),
      .cpu_reset_n    (cpu_w[gi]),
      .done           (done_w[gi]),
      .error          (err_w[gi])
    );
    assign addr_w[gi] = 12'(a);
  end

  int n_chk = 0;
  int n_fail = 0;

  // Model: phase 0 header, 1 loading, 2 done, 3 error
  int          m_phase [2];
  int          m_nb    [2];
  logic [31:0] m_acc   [2];
  longint      m_n     [2];
  longint      m_idx   [2];
  logic        e_wren  [2];
  logic [11:0] e_addr  [2];
  logic [31:0] e_data  [2];
  logic        e_done  [2];
  logic        e_cpu   [2];
  logic        e_err   [2];

  logic [11:0] lg_addr [2][32];
  logic [31:0] lg_data [2][32];
  int          lg_n    [2] = '{0, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_loop();
    logic [31:0] w;
    longint depth;
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        depth = (d == 0) ? 64'd4096 : 64'd4;
        if (rst[d]) begin
          m_phase[d] = 0; m_nb[d] = 0; m_acc[d] = '0; m_n[d] = 0; m_idx[d] = 0;
          e_wren[d] = 1'b0; e_addr[d] = '0; e_data[d] = '0;
          e_done[d] = 1'b0; e_cpu[d] = 1'b0; e_err[d] = 1'b0;
        end else begin
          e_wren[d] = 1'b0;
          if (m_phase[d] <= 1) begin
            if (in_valid[d]) begin
              m_acc[d] = m_acc[d] | (32'(in_data[d]) << (8 * m_nb[d]));
              m_nb[d]++;
              if (m_nb[d] == 4) begin
                w = m_acc[d];
                m_acc[d] = '0;
                m_nb[d] = 0;
                if (m_phase[d] == 0) begin
                  if (w == 0 || longint'(w) > depth) begin
                    m_phase[d] = 3;
                    e_err[d] = 1'b1;
                  end else begin
                    m_n[d] = longint'(w);
                    m_idx[d] = 0;
                    m_phase[d] = 1;
                  end
                end else begin
                  e_wren[d] = 1'b1;
                  e_addr[d] = 12'(m_idx[d]);
                  e_data[d] = w;
                  m_idx[d]++;
                  if (m_idx[d] == m_n[d]) m_phase[d] = 2;
                end
              end
            end
          end else if (m_phase[d] == 2) begin
            if (reload[d]) begin
              m_phase[d] = 0; m_nb[d] = 0; m_acc[d] = '0;
              e_done[d] = 1'b0; e_cpu[d] = 1'b0;
            end else begin
              e_done[d] = 1'b1; e_cpu[d] = 1'b1;
            end
          end else begin
            if (reload[d]) begin
              m_phase[d] = 0; m_nb[d] = 0; m_acc[d] = '0;
              e_err[d] = 1'b0;
            end
          end
        end
      end
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rom_wren_w[d] && lg_n[d] < 32) begin
          lg_addr[d][lg_n[d]] = addr_w[d];
          lg_data[d][lg_n[d]] = data_w[d];
          lg_n[d]++;
        end
        if (rst[d])
          check($sformatf("reset_outputs_%0d", d),
                {rom_wren_w[d], cpu_w[d], done_w[d], err_w[d], addr_w[d], data_w[d]}, 64'd0);
        else
          check($sformatf("model_%0d", d),
                {in_ready_w[d], rom_wren_w[d], cpu_w[d], done_w[d], err_w[d], addr_w[d], data_w[d]},
                {(m_phase[d] <= 1), e_wren[d], e_cpu[d], e_done[d], e_err[d], e_addr[d], e_data[d]});
      end
    end
  endtask

  task automatic send(input int d, input logic [7:0] b);
    @(negedge clk);
    in_data[d]  = b;
    in_valid[d] = 1'b1;
  endtask

  task automatic send_word(input int d, input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(d, w[8*i +: 8]);
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid[d] = 1'b0;
    end
  endtask

  task automatic pulse_reload(input int d);
    @(negedge clk);
    in_valid[d] = 1'b0;
    reload[d] = 1'b1;
    @(negedge clk);
    reload[d] = 1'b0;
  endtask

  initial begin
    int base;
    logic [31:0] w;
    rst = '1; in_valid = '0; reload = '0; in_data = '0;
    fork
      model_loop();
      compare_loop();
    join_none
    repeat (3) @(negedge clk);
    rst = '0;
    @(negedge clk);
    check("reset_ready", {in_ready_w[0], cpu_w[0], done_w[0], err_w[0]}, 4'b1000);

    // Two-word stream, back-to-back
    base = lg_n[0];
    send_word(0, 32'd2); send_word(0, 32'h13); send_word(0, 32'hB7);
    @(negedge clk); in_valid[0] = 1'b0;
    check("t1_last_write", {rom_wren_w[0], done_w[0], cpu_w[0]}, 3'b100);
    @(negedge clk);
    check("t1_done", {rom_wren_w[0], done_w[0], cpu_w[0]}, 3'b011);
    idle(0, 2);
    check("t1_count", lg_n[0] - base, 2);
    check("t1_w0", {lg_addr[0][base], lg_data[0][base]}, {12'h000, 32'h0000_0013});
    check("t1_w1", {lg_addr[0][base+1], lg_data[0][base+1]}, {12'h001, 32'h0000_00B7});

    // Zero header rejected, reload recovers
    pulse_reload(0);
    check("t2_reload_done", {in_ready_w[0], done_w[0], cpu_w[0]}, 3'b100);
    base = lg_n[0];
    send_word(0, 32'd0); idle(0, 3);
    check("t2_error", {err_w[0], in_ready_w[0], cpu_w[0], done_w[0]}, 4'b1000);
    check("t2_no_write", lg_n[0] - base, 0);
    pulse_reload(0);
    check("t2_reload_err", {err_w[0], in_ready_w[0]}, 2'b01);

    // Oversize header (depth+1) rejected
    send_word(0, 32'h1001); idle(0, 2);
    check("t2b_oversize", {err_w[0], in_ready_w[0]}, 2'b10);
    pulse_reload(0);

    // N=1 with a gap after every data byte; reload in LOAD ignored
    base = lg_n[0];
    send_word(0, 32'd1);
    w = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      send(0, w[8*i +: 8]);
      @(negedge clk);
      in_valid[0] = 1'b0;
      reload[0] = (i == 1);
    end
    reload[0] = 1'b0;
    idle(0, 3);
    check("t3_count", lg_n[0] - base, 1);
    check("t3_w0", {lg_addr[0][base], lg_data[0][base]}, {12'h000, 32'hDEADBEEF});
    check("t3_done", {done_w[0], cpu_w[0]}, 2'b11);

    // 2-bit address instance: N=5 rejected, N=4 fills every address
    send_word(1, 32'd5); idle(1, 2);
    check("t4_oversize", err_w[1], 1'b1);
    pulse_reload(1);
    base = lg_n[1];
    send_word(1, 32'd4);
    for (int k = 0; k < 4; k++) send_word(1, 32'hA0A0_0000 + 32'(k));
    idle(1, 3);
    check("t4_count", lg_n[1] - base, 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("t4_w%0d", k), {lg_addr[1][base+k], lg_data[1][base+k]},
            {12'(k), 32'hA0A0_0000 + 32'(k)});
    check("t4_done", {done_w[1], cpu_w[1], err_w[1]}, 3'b110);

    // Reset mid-word discards the partial word
    pulse_reload(0);
    send_word(0, 32'd2); send_word(0, 32'hDDCCBBAA);
    send(0, 8'h11); send(0, 8'h22);
    @(negedge clk); in_valid[0] = 1'b0;
    check("t5_pre_reset_data", data_w[0], 32'hDDCCBBAA);
    #2 rst[0] = 1'b1;
    #1 check("t5_async_reset",
             {rom_wren_w[0], cpu_w[0], done_w[0], err_w[0], addr_w[0], data_w[0]}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst[0] = 1'b0;
    base = lg_n[0];
    send_word(0, 32'd1); send_word(0, 32'h12345678);
    idle(0, 3);
    check("t5_count", lg_n[0] - base, 1);
    check("t5_w0", {lg_addr[0][base], lg_data[0][base]}, {12'h000, 32'h12345678});

    // DONE ignores incoming bytes; reload drops cpu_reset_n next edge
    base = lg_n[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_blocked", {in_ready_w[0], rom_wren_w[0], done_w[0]}, 3'b001);
      in_data[0] = 8'h55;
      in_valid[0] = 1'b1;
    end
    pulse_reload(0);
    check("t6_reload", {cpu_w[0], done_w[0], in_ready_w[0]}, 3'b001);
    check("t6_no_write", lg_n[0] - base, 0);
    idle(0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
